// File: rtl/bus_oe_arb_pkg.sv
// Shared types and counter widths for the tri-state bus output-enable arbiter.
// Optional feature macro: BUS_OE_ARB_TIMEOUT_EN (grant hold-time limit).
package bus_oe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Turnaround gap is at most 15 cycles, hold limit at most 255 cycles.
  localparam int TURN_CNT_W = 4;
  localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans req upward from ptr with wrap and
// reports the first set bit.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] winner
);

  localparam int IDX_W = $clog2(N);

  // (base + off) mod N, with base < N and off < N
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest set bit to ptr wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int o = N - 1; o >= 0; o--) begin
      if (req[wrap_add(ptr, o)]) begin
        valid  = 1'b1;
        winner = wrap_add(ptr, o);
      end
    end
  end

endmodule

// File: rtl/bus_oe_arbiter.sv
// Round-robin owner of a shared tri-state bus. Drives a one-hot (or zero)
// output-enable vector and inserts an all-off turnaround gap between tenures.
// Optional feature macro: BUS_OE_ARB_TIMEOUT_EN limits a tenure to MAX_HOLD
// cycles and pulses preempt when a grant is cut short.
module bus_oe_arbiter
  import bus_oe_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int TURNAROUND = 2,
  parameter int MAX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 preempt
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N - 1);
  localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURNAROUND - 1);

  // Reject illegal configurations at elaboration.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("bus_oe_arbiter: N must be 2..8");
  end
  if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turn
    $error("bus_oe_arbiter: TURNAROUND must be 1..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("bus_oe_arbiter: MAX_HOLD must be 1..255");
  end

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [TURN_CNT_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [N-1:0]          grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  preempt_q, preempt_d;
  logic                  leave_grant;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

`ifdef BUS_OE_ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD);
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  rr_picker #(
    .N(N)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .winner(pick_idx)
  );

  // Next-state logic: IDLE -> GRANT -> TURN -> (GRANT | IDLE).
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    turn_cnt_d  = turn_cnt_q;
    preempt_d   = 1'b0;
    leave_grant = 1'b0;
`ifdef BUS_OE_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
`ifdef BUS_OE_ARB_TIMEOUT_EN
          hold_cnt_d = HOLD_CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        // A normal release takes priority over a simultaneous timeout.
        if (!req[owner_q]) begin
          leave_grant = 1'b1;
        end
`ifdef BUS_OE_ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LIMIT) begin
          leave_grant = 1'b1;
          preempt_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
        if (leave_grant) begin
          state_d    = TURN;
          owner_d    = '0;
          ptr_d      = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          turn_cnt_d = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_cnt_q == '0) begin
          if (pick_valid) begin
            state_d = GRANT;
            owner_d = pick_idx;
`ifdef BUS_OE_ARB_TIMEOUT_EN
            hold_cnt_d = HOLD_CNT_W'(1);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  // One-hot enable for the next owner, zero outside GRANT.
  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign grant_d[gi] = (state_d == GRANT) && (owner_d == IDX_W'(gi));
  end

  assign busy_d = (state_d != IDLE);

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      turn_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
`ifdef BUS_OE_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      turn_cnt_q <= turn_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
`ifdef BUS_OE_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign oe      = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_oe_arbiter.sv
// Directed bench for bus_oe_arbiter with N=4, TURNAROUND=2, MAX_HOLD=8.
// The hold-limit scenario runs when BUS_OE_ARB_TIMEOUT_EN is defined,
// the unlimited-hold scenario otherwise.
module tb_bus_oe_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] oe;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  int check_cnt = 0;
  int pass_cnt  = 0;

  bus_oe_arbiter #(
    .N(4),
    .TURNAROUND(2),
    .MAX_HOLD(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .oe     (oe),
    .owner  (owner),
    .busy   (busy),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++;
    if (oe !== 4'b0000 || grant !== 4'b0000) $display("FAIL reset_oe: oe=%b grant=%b expected 0000", oe, grant);
    else pass_cnt++;
    check_cnt++;
    if (owner !== 2'd0) $display("FAIL reset_owner: got %0d expected 0", owner);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0 || preempt !== 1'b0) $display("FAIL reset_flags: busy=%b preempt=%b expected 0/0", busy, preempt);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [1:0] exp_busy [3];
    exp_busy = '{2'd1, 2'd1, 2'd0};
    do_reset();
    req = 4'b0001;
    tick();
    check_cnt++;
    if (oe !== 4'b0001 || grant !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1)
      $display("FAIL single_grant: oe=%b grant=%b owner=%0d busy=%b expected 0001/0001/0/1", oe, grant, owner, busy);
    else pass_cnt++;
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_cnt++;
      if (oe !== 4'b0000 || busy !== exp_busy[c][0])
        $display("FAIL single_release_c%0d: oe=%b busy=%b expected 0000/%b", c, oe, busy, exp_busy[c][0]);
      else pass_cnt++;
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    int exp_owner;
    logic [3:0] exp_oe;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_owner = k % 4;
      exp_oe = 4'b0001 << exp_owner;
      for (int c = 0; c < 3; c++) begin
        check_cnt++;
        if (oe !== exp_oe || owner !== 2'(exp_owner))
          $display("FAIL rr_tenure%0d_c%0d: oe=%b owner=%0d expected %b/%0d", k, c, oe, owner, exp_oe, exp_owner);
        else pass_cnt++;
        check_cnt++;
        if ($countones(oe) > 1) $display("FAIL rr_onehot: oe=%b expected at most one bit", oe);
        else pass_cnt++;
        if (c < 2) tick();
      end
      req = 4'b1111 & ~exp_oe;
      tick();
      check_cnt++;
      if (oe !== 4'b0000 || busy !== 1'b1) $display("FAIL rr_turn%0d_a: oe=%b busy=%b expected 0000/1", k, oe, busy);
      else pass_cnt++;
      req = 4'b1111;
      tick();
      check_cnt++;
      if (oe !== 4'b0000) $display("FAIL rr_turn%0d_b: oe=%b expected 0000", k, oe);
      else pass_cnt++;
      tick();
    end
    req = 4'b0000;
    $display("test_round_robin done");
  endtask

  task automatic test_wrap();
    int cur;
    int nxt [3];
    nxt = '{3, 0, 1};
    do_reset();
    req = 4'b0100;
    tick();
    check_cnt++;
    if (oe !== 4'b0100 || owner !== 2'd2) $display("FAIL wrap_first: oe=%b owner=%0d expected 0100/2", oe, owner);
    else pass_cnt++;
    cur = 2;
    for (int k = 0; k < 3; k++) begin
      req = (k == 0) ? 4'b1011 : (4'b1111 & ~(4'b0001 << cur));
      tick();
      tick();
      check_cnt++;
      if (oe !== 4'b0000) $display("FAIL wrap_gap%0d: oe=%b expected 0000", k, oe);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (oe !== (4'b0001 << nxt[k]) || owner !== 2'(nxt[k]))
        $display("FAIL wrap_next%0d: oe=%b owner=%0d expected owner %0d", k, oe, owner, nxt[k]);
      else pass_cnt++;
      cur = nxt[k];
    end
    req = 4'b0000;
    $display("test_wrap done");
  endtask

  task automatic test_same_owner();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    check_cnt++;
    if (oe !== 4'b0000) $display("FAIL regrant_gap: oe=%b expected 0000", oe);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (oe !== 4'b0001 || owner !== 2'd0) $display("FAIL regrant: oe=%b owner=%0d expected 0001/0", oe, owner);
    else pass_cnt++;
    req = 4'b0000;
    $display("test_same_owner done");
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    check_cnt++;
    if (oe !== 4'b0100) $display("FAIL midrst_setup: oe=%b expected 0100", oe);
    else pass_cnt++;
    reset = 1'b1;
    req = 4'b1111;
    tick();
    check_cnt++;
    if (oe !== 4'b0000 || owner !== 2'd0 || busy !== 1'b0)
      $display("FAIL midrst_drop: oe=%b owner=%0d busy=%b expected 0000/0/0", oe, owner, busy);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    check_cnt++;
    if (oe !== 4'b0001 || owner !== 2'd0) $display("FAIL midrst_ptr: oe=%b owner=%0d expected 0001/0", oe, owner);
    else pass_cnt++;
    req = 4'b0000;
    $display("test_reset_mid_grant done");
  endtask

`ifdef BUS_OE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] exp_oe;
    do_reset();
    req = 4'b0011;
    tick();
    for (int t = 0; t < 2; t++) begin
      exp_oe = 4'b0001 << t;
      for (int c = 0; c < 8; c++) begin
        check_cnt++;
        if (oe !== exp_oe || preempt !== 1'b0)
          $display("FAIL timeout_hold%0d_c%0d: oe=%b preempt=%b expected %b/0", t, c, oe, preempt, exp_oe);
        else pass_cnt++;
        tick();
      end
      check_cnt++;
      if (oe !== 4'b0000 || preempt !== 1'b1) $display("FAIL timeout_pulse%0d: oe=%b preempt=%b expected 0000/1", t, oe, preempt);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (oe !== 4'b0000 || preempt !== 1'b0) $display("FAIL timeout_gap%0d: oe=%b preempt=%b expected 0000/0", t, oe, preempt);
      else pass_cnt++;
      tick();
    end
    req = 4'b0000;
    $display("test_timeout done");
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 100; c++) begin
      tick();
      check_cnt++;
      if (oe !== 4'b0001 || preempt !== 1'b0)
        $display("FAIL hold_forever_c%0d: oe=%b preempt=%b expected 0001/0", c, oe, preempt);
      else pass_cnt++;
    end
    req = 4'b0000;
    $display("test_no_timeout done");
  endtask
`endif

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_same_owner();
    test_reset_mid_grant();
`ifdef BUS_OE_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/bus_oe_arbiter.md
# bus_oe_arbiter

Round-robin arbiter that shares one tri-state bus between `N` requesters. It drives a one-hot output-enable vector and enforces a guaranteed all-off turnaround gap between owners, so two drivers are never enabled together. It sits between the requesting bus masters and the per-master tri-state buffers, and replaces fixed-sequence OE generation with demand-driven sequencing.

## Interface
- `N`, 4: number of requesters; legal range 2..8.
- `TURNAROUND`, 2: all-off cycles between owners; legal range 1..15.
- `MAX_HOLD`, 8: maximum consecutive grant cycles; only used when `BUS_OE_ARB_TIMEOUT_EN` is defined; legal range 1..255.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  N: `req[i]` is held high while requester i wants the bus.
- `grant`  out  N: one-hot or zero; registered.
- `oe`  out  N: one-hot or zero; drives the tri-state enables; identical to `grant`.
- `owner`  out  $clog2(N): index of the current owner; 0 when no grant.
- `busy`  out  1: high whenever the state is not IDLE.
- `preempt`  out  1: one-cycle pulse when a grant is forcibly ended.

## Operation
- The FSM has three states: IDLE, GRANT, TURN.
- **Round-robin pointer `ptr`:**
  - Search `req` starting at index `ptr`, ascending with wrap; the first set bit wins.
  - On leaving GRANT, `ptr` is set to (owner+1) mod N.
- **IDLE:** `grant`/`oe` = 0. If any `req` bit is set, go to GRANT with the winner.
- **GRANT:** `grant`/`oe` = onehot(owner). Stay while `req[owner]`=1. When `req[owner]`=0, go to TURN.
- **TURN:**
  - `grant`/`oe` = 0; the turnaround counter loads `TURNAROUND`-1 on entry and decrements each cycle.
  - At counter = 0: if any `req` bit is set, go straight to GRANT with the winner; otherwise go to IDLE.
- Other requests arriving during GRANT or TURN wait. No request is queued or latched; only the level on `req` is sampled.
- A requester that drops `req` before being granted is simply skipped.
- **Invariants:**
  - `oe` is never multi-hot.
  - Between any two different owners there are exactly `TURNAROUND` cycles of `oe`=0.
  - The same owner re-granted after release also goes through TURN.
- **Reset:** state=IDLE, `grant`=`oe`=0, `owner`=0, `busy`=0, `preempt`=0, `ptr`=0, all counters 0. Reset asserted mid-GRANT drops `oe` at the next edge.

## Timing
- **Request latency:** `req` sampled high at edge k in IDLE gives `grant`/`oe` high after edge k (one cycle).
- **Release:** `req[owner]` sampled low at edge k gives `oe`=0 after edge k.
  - The next owner's `oe` rises after edge k+`TURNAROUND`.
  - Next-owner selection uses `req` sampled at edge k+`TURNAROUND`.
- **Starvation bound:** a continuously held request is granted within N-1 other tenures.
- **Simultaneous events:** if the owner drops `req` in the same cycle a timeout fires, a normal release occurs and `preempt` stays 0.

## Configuration
- `BUS_OE_ARB_TIMEOUT_EN` defined:
  - A hold counter starts at 1 on entry to GRANT and increments each GRANT cycle.
  - In the GRANT cycle where the counter equals `MAX_HOLD` with `req[owner]` still 1, go to TURN, pulse `preempt` for that one cycle, and advance `ptr` as normal.
  - Result: the owner holds `oe` for exactly `MAX_HOLD` cycles.
  - A preempted requester that keeps `req` high re-competes in round-robin order.
- `BUS_OE_ARB_TIMEOUT_EN` undefined: no hold counter; a grant lasts indefinitely; `preempt` is tied to 0; `MAX_HOLD` is ignored.

## Structure
- Package `bus_oe_arb_pkg`:
  - `arb_state_t` enum (IDLE, GRANT, TURN).
  - Counter width constants.
  - Function `onehot(idx, N)` is not needed; generate the one-hot inline.
- Sub-module `rr_picker`: combinational. Inputs `req` and `ptr`; outputs `valid` and `winner` index. Parameterised by `N`.
- The FSM, counters and output registers live in `bus_oe_arbiter`.

## Test plan
All scenarios use N=4, `TURNAROUND`=2, `MAX_HOLD`=8.
1. Reset, then `req`=0001 → `oe`=0001 one cycle later, `owner`=0, `busy`=1. Drop `req` → `oe`=0000 for 2 cycles, then IDLE with `busy`=0.
2. `req`=1111 held → `oe` sequence 0001, 0000, 0000, 0010, 0000, 0000, 0100, …, with each owner releasing after 3 cycles. Check round-robin order 0,1,2,3,0 and that `oe` is never multi-hot.
3. Owner 2 releases while `req`=1011 → next grant goes to 3, then 0, then 1. Confirms the pointer wraps.
4. Assert `reset` during GRANT with `oe`=0100 → `oe`=0000 at the next edge and `ptr` returns to 0. `req`=1111 afterwards → owner 0 is granted first.
5. With `BUS_OE_ARB_TIMEOUT_EN` defined and `req`=0011 held → owner 0 holds `oe` for exactly 8 cycles, `preempt` pulses once, 2 idle cycles follow, then owner 1 holds for 8 cycles.
6. Without `BUS_OE_ARB_TIMEOUT_EN` and `req`=0011 held for 100 cycles → owner 0 keeps `oe`=0001 throughout and `preempt` stays 0.
